// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential Divide unit among NREQ requesters.
// One division in flight; zero divisors are rejected locally and hung operations time out.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [2:0]        rsp_id,
  output logic [W-1:0]      rsp_q,
  output logic [W-1:0]      rsp_r,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic [W-1:0]      div_d,
  input  logic [W-1:0]      div_r,
  input  logic              div_ok,
  input  logic              div_err,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_ptr;
  logic [2:0]    r_id;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_gnt_vld;
  logic [2:0]    w_gnt;
  logic [2:0]    w_ptr_nxt;
  logic [W-1:0]  w_gnt_a;
  logic [W-1:0]  w_gnt_b;
  logic          w_b_zero;
  logic          w_timeout;

  // First asserted request at or after ptr, wrapping; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] ptr);
    logic [3:0]      res;
    logic [NREQ-1:0] bit_k;
    int              j;
    res = 4'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j     = (int'(ptr) + k) % NREQ;
      bit_k = NREQ'(1) << j;
      if ((v & bit_k) != '0) res = {1'b1, 3'(j)};
    end
    return res;
  endfunction

  always_comb begin
    {w_gnt_vld, w_gnt} = rr_pick(req_valid, r_ptr);
    w_gnt_a   = W'(req_a >> (int'(w_gnt) * W));
    w_gnt_b   = W'(req_b >> (int'(w_gnt) * W));
    w_b_zero  = (w_gnt_b == '0);
    w_ptr_nxt = (int'(w_gnt) == NREQ - 1) ? 3'd0 : w_gnt + 3'd1;
    // Counter increments each idle WAIT cycle; giving up when the incremented
    // value reaches TIMEOUT-1 puts the error response TIMEOUT cycles after div_start.
    w_timeout = ((r_cnt + CW'(1)) == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // req_ready is gated by reset so a requester never sees an accept the FSM ignores.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld && reset) begin
          req_ready = NREQ'(1) << w_gnt;
          w_next    = w_b_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (div_ok || div_err || w_timeout) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= 3'd0;
      r_id  <= 3'd0;
      r_a   <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_a   <= w_gnt_a;
            r_b   <= w_gnt_b;
            r_id  <= w_gnt;
            r_ptr <= w_ptr_nxt;
            r_q   <= '0;
            r_r   <= '0;
            r_err <= w_b_zero;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          // An error flag wins even when ok arrives in the same cycle.
          if (div_err) begin
            r_err <= 1'b1;
            r_q   <= '0;
            r_r   <= '0;
          end else if (div_ok) begin
            r_err <= 1'b0;
            r_q   <= div_d;
            r_r   <= div_r;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_q   <= '0;
            r_r   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign div_a   = r_a;
  assign div_b   = r_b;
  assign rsp_id  = r_id;
  assign rsp_q   = r_q;
  assign rsp_r   = r_r;
  assign rsp_err = r_err;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios plus randomized traffic against a
// queue-based round-robin/division reference model and a behavioural Divide stub.
module tb_div_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;
  localparam logic [W-1:0] ERR_B  = 32'd7;
  localparam logic [W-1:0] BOTH_B = 32'd11;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [W-1:0]      rsp_q;
  logic [W-1:0]      rsp_r;
  logic              rsp_err;
  logic              rsp_ready;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic [W-1:0]      div_d;
  logic [W-1:0]      div_r;
  logic              div_ok;
  logic              div_err;
  logic              busy;

  logic s_ok, s_err, inj_ok, s_pend;
  int   s_cnt;
  logic [W-1:0] s_a, s_b;
  bit   stub_hang;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { int id; logic [W-1:0] q; logic [W-1:0] r; logic err; } rsp_t;

  op_t  pend [NREQ][$];
  rsp_t expq[$];
  int   gnt_log[$];

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_d(div_d), .div_r(div_r), .div_ok(div_ok), .div_err(div_err),
    .busy(busy)
  );

  assign div_ok  = s_ok | inj_ok;
  assign div_err = s_err;

  // Divide stub: random 1..6 cycle latency; divisor ERR_B raises err, BOTH_B raises ok and err.
  always @(posedge clk) begin
    s_ok  <= 1'b0;
    s_err <= 1'b0;
    if (!reset) begin
      s_pend <= 1'b0;
    end else if (div_start) begin
      s_pend <= 1'b1;
      s_cnt  <= $urandom_range(1, 6);
      s_a    <= div_a;
      s_b    <= div_b;
    end else if (s_pend) begin
      if (s_cnt <= 1) begin
        s_pend <= 1'b0;
        if (!stub_hang) begin
          if (s_b == ERR_B) begin
            s_err <= 1'b1;
          end else begin
            s_ok <= 1'b1;
            if (s_b == BOTH_B) s_err <= 1'b1;
            if (s_b != '0) begin
              div_d <= s_a / s_b;
              div_r <= s_a % s_b;
            end
          end
        end
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  function automatic rsp_t ref_div(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t e;
    e.id = id; e.q = '0; e.r = '0; e.err = 1'b1;
    if (b != '0 && b != ERR_B && b != BOTH_B) begin
      e.q = a / b; e.r = a % b; e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] gen_b();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return ERR_B;
      2:       return BOTH_B;
      3, 4:    return $urandom_range(1, 100);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0; inj_ok = 1'b0; stub_hang = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_traffic(input int rdy_pct, input int budget);
    int ptr, cyc, g, j, any;
    bit infl;
    logic [NREQ-1:0] exp_rdy;
    rsp_t e;
    op_t  o;
    ptr = 0; cyc = 0; infl = 1'b0;
    expq.delete(); gnt_log.delete();
    any = 1;
    while ((any != 0 || expq.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (pend[i].size() > 0);
        if (pend[i].size() > 0) begin
          req_a[i*W +: W] = pend[i][0].a;
          req_b[i*W +: W] = pend[i][0].b;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      exp_rdy = '0; g = -1;
      if (!infl) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr + k) % NREQ;
          if (g < 0 && pend[j].size() > 0) g = j;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL grant cyc=%0d: req_ready=%b expected %b", cyc, req_ready, exp_rdy);
      end
      tests++;
      if (busy !== infl) begin
        fails++;
        $display("FAIL busy cyc=%0d: busy=%b expected %b", cyc, busy, infl);
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) gnt_log.push_back(i);
      if (g >= 0) begin
        o = pend[g].pop_front();
        expq.push_back(ref_div(g, o.a, o.b));
        ptr  = (g + 1) % NREQ;
        infl = 1'b1;
      end
      if (rsp_valid === 1'b1) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp cyc=%0d: rsp_valid=1 with no request outstanding", cyc);
        end else begin
          e = expq[0];
          if (rsp_id !== 3'(e.id) || rsp_q !== e.q || rsp_r !== e.r || rsp_err !== e.err) begin
            fails++;
            $display("FAIL rsp cyc=%0d: id=%0d q=%h r=%h err=%b expected id=%0d q=%h r=%h err=%b",
                     cyc, rsp_id, rsp_q, rsp_r, rsp_err, e.id, e.q, e.r, e.err);
          end
          if (rsp_ready) begin
            void'(expq.pop_front());
            infl = 1'b0;
          end
        end
      end
      any = 0;
      for (int i = 0; i < NREQ; i++) any += pend[i].size();
    end
    req_valid = '0;
    tests++;
    if (cyc >= budget) begin
      fails++;
      $display("FAIL traffic_budget: %0d cycles used, limit %0d, %0d responses outstanding",
               cyc, budget, expq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (req_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b expected 0", req_ready);
    end
    tests++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: v=%b id=%0d q=%h r=%h err=%b st=%b a=%h b=%h busy=%b expected all 0",
               rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b, busy);
    end
    req_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_a[0 +: W] = 32'd1023; req_b[0 +: W] = 32'd50; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_accept: req_ready=%b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    tests++;
    if (div_start !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_start: div_start=%b busy=%b expected 1 1", div_start, busy);
    end
    @(negedge clk);
    #1;
    tests++;
    if (div_start !== 1'b0 || div_a !== 32'd1023 || div_b !== 32'd50) begin
      fails++; $display("FAIL single_hold: div_start=%b a=%0d b=%0d expected 0 1023 50", div_start, div_a, div_b);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_q !== 32'd20 || rsp_r !== 32'd23 || rsp_id !== 3'd0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL single_rsp: v=%b q=%0d r=%0d id=%0d err=%b expected 1 20 23 0 0",
               rsp_valid, rsp_q, rsp_r, rsp_id, rsp_err);
    end
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_idle: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_rr_order();
    int exp_order [5];
    op_t o;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 2; n++) begin
        o.a = $urandom; o.b = $urandom_range(1, 1000);
        pend[i].push_back(o);
      end
    do_reset();
    run_traffic(100, 400);
    tests++;
    if (gnt_log.size() < 5) begin
      fails++; $display("FAIL rr_count: %0d grants seen, expected at least 5", gnt_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (gnt_log[k] != exp_order[k]) begin
          fails++; $display("FAIL rr_order[%0d]: granted %0d expected %0d", k, gnt_log[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_a[2*W +: W] = 32'd7; req_b[2*W +: W] = '0; rsp_ready = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0100 || div_start !== 1'b0) begin
      fails++; $display("FAIL zero_accept: req_ready=%b div_start=%b expected 0100 0", req_ready, div_start);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_q !== '0 || rsp_r !== '0 || rsp_id !== 3'd2 || div_start !== 1'b0) begin
      fails++;
      $display("FAIL zero_rsp: v=%b err=%b q=%h r=%h id=%0d start=%b expected 1 1 0 0 2 0",
               rsp_valid, rsp_err, rsp_q, rsp_r, rsp_id, div_start);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || div_start !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_done: v=%b start=%b busy=%b expected 0 0 0", rsp_valid, div_start, busy);
    end
  endtask

  task automatic test_timeout();
    int n, t_start, t_rsp, starts;
    do_reset();
    stub_hang = 1'b1;
    @(negedge clk);
    req_valid = 4'b0010; req_a[W +: W] = 32'd100; req_b[W +: W] = 32'd3; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL tmo_accept: req_ready=%b expected 0010", req_ready); end
    n = 0; t_start = -1; t_rsp = -1; starts = 0;
    while (t_rsp < 0 && n < 4 * TIMEOUT) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      n++;
      if (div_start === 1'b1) begin starts++; if (t_start < 0) t_start = n; end
      if (rsp_valid === 1'b1) t_rsp = n;
    end
    tests++;
    if (t_rsp < 0 || t_start < 0 || (t_rsp - t_start) != TIMEOUT) begin
      fails++; $display("FAIL tmo_delay: start at %0d rsp at %0d, expected rsp %0d cycles after start", t_start, t_rsp, TIMEOUT);
    end
    tests++;
    if (starts != 1) begin fails++; $display("FAIL tmo_start_pulse: %0d start cycles expected 1", starts); end
    tests++;
    if (rsp_err !== 1'b1 || rsp_q !== '0 || rsp_r !== '0 || rsp_id !== 3'd1) begin
      fails++; $display("FAIL tmo_rsp: err=%b q=%h r=%h id=%0d expected 1 0 0 1", rsp_err, rsp_q, rsp_r, rsp_id);
    end
    @(negedge clk);
    stub_hang = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    int n;
    a = $urandom;
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000; req_a[3*W +: W] = a; req_b[3*W +: W] = 32'd9; rsp_ready = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_accept: req_ready=%b expected 1000", req_ready); end
    n = 0;
    do begin
      @(negedge clk);
      req_valid = '1;
      for (int i = 0; i < 3; i++) begin req_a[i*W +: W] = $urandom; req_b[i*W +: W] = $urandom_range(1, 50); end
      #1;
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_q !== a / 32'd9 || rsp_r !== a % 32'd9 || rsp_id !== 3'd3 ||
          rsp_err !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: v=%b q=%h r=%h id=%0d err=%b rdy=%b busy=%b expected 1 %h %h 3 0 0000 1",
                 c, rsp_valid, rsp_q, rsp_r, rsp_id, rsp_err, req_ready, busy, a / 32'd9, a % 32'd9);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++; $display("FAIL bp_release: v=%b busy=%b rdy=%b expected 0 0 0000", rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    do_reset();
    stub_hang = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001; req_a[0 +: W] = 32'd500; req_b[0 +: W] = 32'd4; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || div_start !== 1'b0 || div_a !== 32'd500) begin
      fails++; $display("FAIL rw_wait: busy=%b start=%b a=%0d expected 1 0 500", busy, div_start, div_a);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b, busy} !== '0) begin
      fails++;
      $display("FAIL rw_reset: rdy=%b v=%b id=%0d q=%h r=%h err=%b st=%b a=%h b=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b, busy);
    end
    reset = 1'b1; stub_hang = 1'b0; inj_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inj_ok = 1'b0;
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || div_start !== 1'b0) begin
        fails++; $display("FAIL rw_late_ok[%0d]: v=%b busy=%b start=%b expected 0 0 0", c, rsp_valid, busy, div_start);
      end
    end
    @(negedge clk);
    req_valid = 4'b0010; req_a[W +: W] = 32'd81; req_b[W +: W] = 32'd9;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL rw_regrant: req_ready=%b expected 0010", req_ready); end
    n = 0;
    do begin @(negedge clk); req_valid = '0; #1; n++; end while (rsp_valid !== 1'b1 && n < 20);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_q !== 32'd9 || rsp_r !== 32'd0 || rsp_id !== 3'd1 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL rw_after: v=%b q=%0d r=%0d id=%0d err=%b expected 1 9 0 1 0", rsp_valid, rsp_q, rsp_r, rsp_id, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    op_t o;
    for (int n = 0; n < 40; n++) begin
      o.a = $urandom; o.b = gen_b();
      pend[$urandom_range(0, NREQ - 1)].push_back(o);
    end
    do_reset();
    run_traffic(60, 3000);
  endtask

  task automatic test_back_to_back();
    op_t o;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 6; n++) begin
        o.a = $urandom; o.b = gen_b();
        pend[i].push_back(o);
      end
    do_reset();
    run_traffic(100, 2000);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    inj_ok = 1'b0; stub_hang = 1'b0;
    test_reset();
    test_single();
    test_rr_order();
    test_div_zero();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
